// File: rtl/gate_pipe_unit_pkg.sv
// Shared opcodes, widths and defaults for the gate experiments.
// Imported by gate_func and gate_pipe_unit.
package gate_pipe_unit_pkg;

   localparam int OP_W      = 3;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = 16;

   localparam logic [OP_W-1:0] OP_NAND = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_OR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/gate_pipe_unit_func.sv
// gate_func: combinational bitwise 2-input logic function.
// y is unused by NOT and PASS.
module gate_func
   import gate_pipe_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z
);

   // Opcode select of the bitwise function
   always_comb begin
      z = '0;
      case (op)
         OP_NAND: z = ~(x & y);
         OP_AND:  z = x & y;
         OP_NOR:  z = ~(x | y);
         OP_OR:   z = x | y;
         OP_XOR:  z = x ^ y;
         OP_XNOR: z = ~(x ^ y);
         OP_NOT:  z = ~x;
         OP_PASS: z = x;
         default: z = '0;
      endcase
   end

endmodule

// File: rtl/gate_pipe_unit.sv
// gate_pipe_unit: gate function feeding a DEPTH-entry result FIFO.
// Optional pop counter enabled by GATE_STATS_EN.
module gate_pipe_unit
   import gate_pipe_unit_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [OP_W-1:0]          in_op,
   input  logic [WIDTH-1:0]         in_x,
   input  logic [WIDTH-1:0]         in_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_z,
   output logic [OP_W-1:0]          out_op,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     stat_clr,
   output logic [CNT_W-1:0]         stat_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic [WIDTH-1:0] z_mem_q [DEPTH];
   logic [OP_W-1:0]  op_mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] hold_z_q;
   logic [OP_W-1:0]  hold_op_q;
   logic [WIDTH-1:0] func_z;
   logic             push, pop;

   assign in_ready  = (level_q != FULL);
   assign out_valid = (level_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign level     = level_q;

   // Empty FIFO shows the last popped entry
   assign out_z  = out_valid ? z_mem_q[rd_ptr_q]  : hold_z_q;
   assign out_op = out_valid ? op_mem_q[rd_ptr_q] : hold_op_q;

   gate_func #(.WIDTH(WIDTH)) u_func (
      .op (in_op),
      .x  (in_x),
      .y  (in_y),
      .z  (func_z)
   );

   // Pointer and level next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointer and level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // FIFO storage and last-popped hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            z_mem_q[i]  <= '0;
            op_mem_q[i] <= '0;
         end
         hold_z_q  <= '0;
         hold_op_q <= '0;
      end else begin
         if (push) begin
            z_mem_q[wr_ptr_q]  <= func_z;
            op_mem_q[wr_ptr_q] <= in_op;
         end
         if (pop) begin
            hold_z_q  <= z_mem_q[rd_ptr_q];
            hold_op_q <= op_mem_q[rd_ptr_q];
         end
      end
   end

`ifdef GATE_STATS_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturating pop counter, clear has priority
   always_comb begin
      cnt_d = cnt_q;
      if (stat_clr)
         cnt_d = '0;
      else if (pop && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign stat_count = cnt_q;
`else
   logic stat_unused;
   assign stat_unused = stat_clr;
   assign stat_count  = '0;
`endif

endmodule
